// File: rtl/pingpong_writer.sv
// pingpong_writer: packs a free-running sample stream into 2^ADDR_W-word frames on a ping-pong RAM write port
//   clk, rst (async, active-low) | in_valid/in_data/in_ready: sample stream
//   addra/wea/dina: RAM A-side write port | finisha: bank-full pulse | readya: bank free
//   frame_cnt: completed frames (wraps) | drop_cnt: samples lost while not ready (saturates)
module pingpong_writer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int SWAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addra,
  output logic              wea,
  output logic [DATA_W-1:0] dina,
  output logic              finisha,
  input  logic              readya,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);
  typedef enum logic [2:0] {IDLE, FILL, FLUSH, FINISH, HOLD} state_t;
  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [3:0]        hold_cnt;
  logic              accept;
  assign accept = in_ready & in_valid;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      wea       <= 1'b0;
      addra     <= '0;
      dina      <= '0;
      finisha   <= 1'b0;
      wr_ptr    <= '0;
      hold_cnt  <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      wea     <= accept;
      finisha <= 1'b0;
      if (in_valid && !in_ready && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (accept) begin
        addra  <= wr_ptr;
        dina   <= in_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      case (state)
        IDLE:
          if (readya) begin
            state    <= FILL;
            in_ready <= 1'b1;
            wr_ptr   <= '0;
          end
        FILL:
          if (accept && wr_ptr == '1) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end
        FLUSH: begin
          state   <= FINISH;
          finisha <= 1'b1;
        end
        FINISH: begin
          state     <= HOLD;
          hold_cnt  <= 4'(SWAP_CYC);
          frame_cnt <= frame_cnt + 16'd1;
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 4'd1;
          if (hold_cnt <= 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
